lrsc_resv_table: RTL and testbench
==================================

Name: lrsc_resv_table

Overview:
- Multi-hart load-reserved/store-conditional reservation tracker shared by NHARTS harts at the point where their memory requests are serialised (one request per cycle) ahead of the shared cache/bus.
- Keeps one reservation per hart (valid, granule address, expiry counter).
- Squashes failing SCs. Invalidates other harts' reservations on conflicting stores or external snoops. Expires stale reservations after a programmable timeout.

Parameters:
- NHARTS, 2, number of harts tracked (1..16).
- PA_BITS, 56, physical address width.
- GRAN_BITS, 3, log2 of reservation granule in bytes; address compare uses PAdr[PA_BITS-1:GRAN_BITS].
- TIMEOUT, 128, cycles a reservation stays live after LR; 0 disables expiry.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- StallW  in  1  Writeback stall; request-driven state updates and SquashSCW are held while high
- ReqValidM  in  1  a request is present this cycle
- ReqHartM  in  $clog2(NHARTS) (min 1)  issuing hart index
- PreLSURWM  in  2  requested operation: [1] read, [0] write
- LSUAtomicM  in  2  atomic type; [0]=1 marks LR (with read) or SC (with write)
- PAdrM  in  PA_BITS  request physical address
- SnoopValid  in  1  external write/invalidate observed (DMA, other agent)
- SnoopPAdr  in  PA_BITS  snoop address
- LSURWM  out  2  operation after SC squash
- SquashSCW  out  1  registered: SC failed, suppress rd=0 writeback
- ReservationValidW  out  NHARTS  per-hart reservation valid (debug/perf)

Behaviour:
- Clock and reset: one clock `clk`. Reset is synchronous and active-high on `reset`.
- Reset: all valid bits 0, addresses 0, counters 0, SquashSCW 0.
- Decode (only when ReqValidM=1):
  - lrM = PreLSURWM[1] & LSUAtomicM[0]
  - scM = PreLSURWM[0] & LSUAtomicM[0]
  - stM = PreLSURWM[0]
  - h = ReqHartM
- Granule match: gadr(x) = x[PA_BITS-1:GRAN_BITS].
- SC success (combinational, cycle M) requires all of:
  - valid[h]=1
  - resadr[h]=gadr(PAdrM)
  - no same-cycle SnoopValid with gadr(SnoopPAdr)=resadr[h]
- SquashSCM = scM & ~success. LSURWM = 00 when SquashSCM, else PreLSURWM (passes through unchanged when ReqValidM=0).
- SquashSCW: register of SquashSCM, enabled by ~StallW; 1-cycle latency.
- State updates are applied at the clock edge, in this priority order (later overrides earlier):
  1. Timeout: each valid[i] with TIMEOUT≠0 decrements counter[i] every cycle, independent of StallW. valid[i] clears when counter[i]=1 decrements to 0.
  2. Snoop: SnoopValid clears every valid[i] whose resadr matches, independent of StallW.
  3. Foreign store (gated by ~StallW): a non-squashed stM from hart h clears valid[j] for all j≠h with matching resadr. A successful SC counts as a store; a squashed SC does not.
  4. Own SC (gated by ~StallW): scM clears valid[h], whether it succeeds or fails.
  5. LR (gated by ~StallW): lrM sets valid[h]=1, resadr[h]=gadr(PAdrM), counter[h]=TIMEOUT. This overrides a same-cycle snoop or timeout on hart h.
- Own plain store by h to its own reserved granule does not clear valid[h].
- LR by h to a new address replaces any prior reservation of h. Only one reservation per hart.
- StallW=1 with a request held: request effects are not applied. Snoop and timeout still apply, so LSURWM may change from pass to squash during the stall; SquashSCW holds its value.
- ReservationValidW = valid vector, registered.

Test Plan:
- Basic LR/SC, NHARTS=2, GRAN_BITS=3, TIMEOUT=128: hart0 LR 0x1000, 5 cycles later hart0 SC 0x1004 → LSURWM=01, SquashSCW=0 next cycle, ReservationValidW[0]=0 after SC.
- SC address mismatch: hart0 LR 0x1000; hart0 SC 0x1008 → LSURWM=00, SquashSCW=1; a second SC to 0x1000 also fails, because the first SC cleared the reservation.
- Cross-hart invalidate: hart0 LR 0x2000, hart1 LR 0x2000; hart1 plain SW 0x2004 → valid=2'b10. hart0 SC 0x2000 squashed; hart1 SC 0x2000 succeeds.
- Snoop race: hart1 LR 0x3000. Same cycle as hart1 SC 0x3000, SnoopValid with 0x3006 → LSURWM=00, SquashSCW=1, valid[1]=0. Separately, snoop same cycle as LR → valid stays 1.
- Timeout, TIMEOUT=4: hart0 LR at cycle t → valid[0]=1 for cycles t+1..t+4, 0 at t+5; SC at t+6 squashed. TIMEOUT=0: SC after 1000 cycles succeeds.
- Stall and reset:
  - hart0 SC held with StallW=1 for 3 cycles → SquashSCW unchanged; valid[0] unchanged until StallW falls, then cleared.
  - Reset asserted mid-reservation → all valid 0 and SquashSCW 0 on the next edge; a subsequent SC is squashed.

Source files
------------

// File: rtl/lrsc_resv_table_if.sv
// Serialised LSU request bus seen by the LR/SC reservation table.
// The master drives the request; the slave returns the possibly squashed op and the SC squash flag.
interface lrsc_resv_table_if #(
    parameter int unsigned NHARTS  = 2,
    parameter int unsigned PA_BITS = 56
);
    localparam int unsigned HART_BITS = (NHARTS > 1) ? $clog2(NHARTS) : 1;

    logic                 ReqValidM;
    logic [HART_BITS-1:0] ReqHartM;
    logic [1:0]           PreLSURWM;
    logic [1:0]           LSUAtomicM;
    logic [PA_BITS-1:0]   PAdrM;
    logic [1:0]           LSURWM;
    logic                 SquashSCW;

    modport master (
        output ReqValidM, ReqHartM, PreLSURWM, LSUAtomicM, PAdrM,
        input  LSURWM, SquashSCW
    );

    modport slave (
        input  ReqValidM, ReqHartM, PreLSURWM, LSUAtomicM, PAdrM,
        output LSURWM, SquashSCW
    );
endinterface

// File: rtl/lrsc_resv_table.sv
// Per-hart load-reserved/store-conditional reservation tracker at the serialised memory port.
// Squashes failing SCs, invalidates on foreign stores and snoops, and expires stale reservations.
module lrsc_resv_table #(
    parameter int unsigned NHARTS    = 2,
    parameter int unsigned PA_BITS   = 56,
    parameter int unsigned GRAN_BITS = 3,
    parameter int unsigned TIMEOUT   = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 StallW,
    input  logic                 SnoopValid,
    input  logic [PA_BITS-1:0]   SnoopPAdr,
    lrsc_resv_table_if.slave     bus,
    output logic [NHARTS-1:0]    ReservationValidW
);
    localparam int unsigned HART_BITS = (NHARTS > 1) ? $clog2(NHARTS) : 1;
    localparam int unsigned GA_BITS   = PA_BITS - GRAN_BITS;
    localparam int unsigned CNT_BITS  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef logic [GA_BITS-1:0]  gadr_t;
    typedef logic [CNT_BITS-1:0] cnt_t;

    logic [NHARTS-1:0] validQ, validD;
    gadr_t             resAdrQ [NHARTS];
    gadr_t             resAdrD [NHARTS];
    cnt_t              cntQ    [NHARTS];
    cnt_t              cntD    [NHARTS];
    logic              squashQ;

    logic  reqLr, reqSc, reqSt;
    gadr_t reqGadr, snpGadr;
    logic  selValid;
    gadr_t selAdr;
    logic  scSuccess, squashM, storeEff, isOwn;

    // Byte-offset bits and the upper atomic-type bit take no part in reservation tracking.
    logic unusedBits;
    assign unusedBits = ^{bus.LSUAtomicM[1], bus.PAdrM[GRAN_BITS-1:0], SnoopPAdr[GRAN_BITS-1:0]};

    assign reqLr   = bus.ReqValidM & bus.PreLSURWM[1] & bus.LSUAtomicM[0];
    assign reqSc   = bus.ReqValidM & bus.PreLSURWM[0] & bus.LSUAtomicM[0];
    assign reqSt   = bus.ReqValidM & bus.PreLSURWM[0];
    assign reqGadr = bus.PAdrM[PA_BITS-1:GRAN_BITS];
    assign snpGadr = SnoopPAdr[PA_BITS-1:GRAN_BITS];

    // Compare against the hart index rather than indexing, so out-of-range harts select nothing.
    always_comb begin
        selValid = 1'b0;
        selAdr   = '0;
        for (int i = 0; i < int'(NHARTS); i++) begin
            if (HART_BITS'(i) == bus.ReqHartM) begin
                selValid = validQ[i];
                selAdr   = resAdrQ[i];
            end
        end
    end

    assign scSuccess  = selValid & (selAdr == reqGadr) & ~(SnoopValid & (snpGadr == selAdr));
    assign squashM    = reqSc & ~scSuccess;
    assign storeEff   = reqSt & ~squashM & ~StallW;
    assign bus.LSURWM = squashM ? 2'b00 : bus.PreLSURWM;

    // Later updates override earlier ones: timeout, snoop, foreign store, own SC, LR.
    always_comb begin
        validD = validQ;
        isOwn  = 1'b0;
        for (int i = 0; i < int'(NHARTS); i++) begin
            resAdrD[i] = resAdrQ[i];
            cntD[i]    = cntQ[i];
            isOwn      = (HART_BITS'(i) == bus.ReqHartM);

            if ((TIMEOUT != 0) && validQ[i]) begin
                cntD[i] = cntQ[i] - 1'b1;
                if (cntQ[i] == cnt_t'(1)) begin
                    validD[i] = 1'b0;
                end
            end

            if (SnoopValid && (resAdrQ[i] == snpGadr)) begin
                validD[i] = 1'b0;
            end

            if (storeEff && !isOwn && (resAdrQ[i] == reqGadr)) begin
                validD[i] = 1'b0;
            end

            if (!StallW && reqSc && isOwn) begin
                validD[i] = 1'b0;
            end

            if (!StallW && reqLr && isOwn) begin
                validD[i]  = 1'b1;
                resAdrD[i] = reqGadr;
                cntD[i]    = cnt_t'(TIMEOUT);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            validQ  <= '0;
            squashQ <= 1'b0;
            for (int i = 0; i < int'(NHARTS); i++) begin
                resAdrQ[i] <= '0;
                cntQ[i]    <= '0;
            end
        end else begin
            validQ <= validD;
            for (int i = 0; i < int'(NHARTS); i++) begin
                resAdrQ[i] <= resAdrD[i];
                cntQ[i]    <= cntD[i];
            end
            if (!StallW) begin
                squashQ <= squashM;
            end
        end
    end

    assign bus.SquashSCW      = squashQ;
    assign ReservationValidW  = validQ;
endmodule

// File: tb/tb_lrsc_resv_table.sv
// Directed bench for lrsc_resv_table: three instances (TIMEOUT 128, 4, 0) share one stimulus stream.
module tb_lrsc_resv_table;
    logic        clk;
    logic        reset;
    logic        StallW;
    logic        SnoopValid;
    logic [55:0] SnoopPAdr;
    logic [1:0]  rvA, rvB, rvC;

    int checks   = 0;
    int failures = 0;

    lrsc_resv_table_if #(.NHARTS(2), .PA_BITS(56)) ifA ();
    lrsc_resv_table_if #(.NHARTS(2), .PA_BITS(56)) ifB ();
    lrsc_resv_table_if #(.NHARTS(2), .PA_BITS(56)) ifC ();

    lrsc_resv_table #(.NHARTS(2), .PA_BITS(56), .GRAN_BITS(3), .TIMEOUT(128)) dutA (
        .clk(clk), .reset(reset), .StallW(StallW), .SnoopValid(SnoopValid),
        .SnoopPAdr(SnoopPAdr), .bus(ifA.slave), .ReservationValidW(rvA)
    );
    lrsc_resv_table #(.NHARTS(2), .PA_BITS(56), .GRAN_BITS(3), .TIMEOUT(4)) dutB (
        .clk(clk), .reset(reset), .StallW(StallW), .SnoopValid(SnoopValid),
        .SnoopPAdr(SnoopPAdr), .bus(ifB.slave), .ReservationValidW(rvB)
    );
    lrsc_resv_table #(.NHARTS(2), .PA_BITS(56), .GRAN_BITS(3), .TIMEOUT(0)) dutC (
        .clk(clk), .reset(reset), .StallW(StallW), .SnoopValid(SnoopValid),
        .SnoopPAdr(SnoopPAdr), .bus(ifC.slave), .ReservationValidW(rvC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setReq(input logic v, input logic h, input logic [1:0] rw,
                          input logic [1:0] at, input logic [55:0] adr);
        ifA.ReqValidM = v; ifA.ReqHartM = h; ifA.PreLSURWM = rw; ifA.LSUAtomicM = at; ifA.PAdrM = adr;
        ifB.ReqValidM = v; ifB.ReqHartM = h; ifB.PreLSURWM = rw; ifB.LSUAtomicM = at; ifB.PAdrM = adr;
        ifC.ReqValidM = v; ifC.ReqHartM = h; ifC.PreLSURWM = rw; ifC.LSUAtomicM = at; ifC.PAdrM = adr;
    endtask

    task automatic lr(input logic h, input logic [55:0] adr);
        setReq(1'b1, h, 2'b10, 2'b01, adr);
    endtask
    task automatic sc(input logic h, input logic [55:0] adr);
        setReq(1'b1, h, 2'b01, 2'b01, adr);
    endtask
    task automatic sw(input logic h, input logic [55:0] adr);
        setReq(1'b1, h, 2'b01, 2'b00, adr);
    endtask
    task automatic idle();
        setReq(1'b0, 1'b0, 2'b00, 2'b00, 56'h0);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; StallW = 1'b0; SnoopValid = 1'b0; SnoopPAdr = '0;
        idle();
        tick(); tick();
        chk("reset_valid", 64'(rvA), 64'h0);
        chk("reset_squash", 64'(ifA.SquashSCW), 64'h0);
        reset = 1'b0;

        // Basic LR/SC
        lr(1'b0, 56'h1000); tick();
        chk("basic_lr_valid", 64'(rvA), 64'h1);
        idle(); repeat (4) tick();
        sc(1'b0, 56'h1004); @(negedge clk);
        chk("basic_sc_rw", 64'(ifA.LSURWM), 64'h1);
        tick();
        chk("basic_sc_squash", 64'(ifA.SquashSCW), 64'h0);
        chk("basic_sc_valid", 64'(rvA), 64'h0);

        // SC address mismatch, then retry on a cleared reservation
        lr(1'b0, 56'h1000); tick();
        sc(1'b0, 56'h1008); @(negedge clk);
        chk("mis_sc_rw", 64'(ifA.LSURWM), 64'h0);
        tick();
        chk("mis_sc_squash", 64'(ifA.SquashSCW), 64'h1);
        chk("mis_sc_valid", 64'(rvA), 64'h0);
        sc(1'b0, 56'h1000); @(negedge clk);
        chk("retry_sc_rw", 64'(ifA.LSURWM), 64'h0);
        tick();
        chk("retry_sc_squash", 64'(ifA.SquashSCW), 64'h1);
        idle(); tick();
        chk("idle_squash", 64'(ifA.SquashSCW), 64'h0);

        // Cross-hart invalidate
        lr(1'b0, 56'h2000); tick();
        lr(1'b1, 56'h2000); tick();
        chk("xh_both_valid", 64'(rvA), 64'h3);
        sw(1'b1, 56'h2004); tick();
        chk("xh_store_valid", 64'(rvA), 64'h2);
        sc(1'b0, 56'h2000); @(negedge clk);
        chk("xh_h0_sc_rw", 64'(ifA.LSURWM), 64'h0);
        tick();
        chk("xh_h0_sc_squash", 64'(ifA.SquashSCW), 64'h1);
        sc(1'b1, 56'h2000); @(negedge clk);
        chk("xh_h1_sc_rw", 64'(ifA.LSURWM), 64'h1);
        tick();
        chk("xh_h1_sc_squash", 64'(ifA.SquashSCW), 64'h0);
        chk("xh_after_valid", 64'(rvA), 64'h0);

        // Snoop races
        lr(1'b1, 56'h3000); tick();
        sc(1'b1, 56'h3000); SnoopValid = 1'b1; SnoopPAdr = 56'h3006; @(negedge clk);
        chk("snp_sc_rw", 64'(ifA.LSURWM), 64'h0);
        tick();
        chk("snp_sc_squash", 64'(ifA.SquashSCW), 64'h1);
        chk("snp_sc_valid", 64'(rvA), 64'h0);
        lr(1'b1, 56'h3000); SnoopPAdr = 56'h3000; tick();
        chk("snp_lr_valid", 64'(rvA), 64'h2);
        idle(); SnoopPAdr = 56'h3004; tick();
        chk("snp_clear_valid", 64'(rvA), 64'h0);
        SnoopValid = 1'b0;
        lr(1'b0, 56'h4000); tick();
        idle(); SnoopValid = 1'b1; SnoopPAdr = 56'h4008; tick();
        chk("snp_other_gran", 64'(rvA), 64'h1);
        SnoopValid = 1'b0;
        sw(1'b0, 56'h4000); tick();
        chk("own_store_keeps", 64'(rvA), 64'h1);

        // Reset mid-reservation with SquashSCW set
        sc(1'b1, 56'h4000); @(negedge clk);
        chk("nores_sc_rw", 64'(ifA.LSURWM), 64'h0);
        tick();
        chk("nores_sc_squash", 64'(ifA.SquashSCW), 64'h1);
        chk("nores_sc_valid", 64'(rvA), 64'h1);
        idle(); reset = 1'b1; tick();
        chk("midreset_valid", 64'(rvA), 64'h0);
        chk("midreset_squash", 64'(ifA.SquashSCW), 64'h0);
        reset = 1'b0;
        sc(1'b0, 56'h4000); @(negedge clk);
        chk("postreset_sc_rw", 64'(ifA.LSURWM), 64'h0);
        tick();
        chk("postreset_sc_squash", 64'(ifA.SquashSCW), 64'h1);

        // Timeout = 4
        lr(1'b0, 56'h5000); tick();
        idle();
        chk("to_valid_t1", 64'(rvB), 64'h1);
        for (int k = 2; k <= 4; k++) begin
            tick();
            chk("to_valid_live", 64'(rvB), 64'h1);
        end
        tick();
        chk("to_valid_t5", 64'(rvB), 64'h0);
        tick();
        sc(1'b0, 56'h5000); @(negedge clk);
        chk("to_sc_rw", 64'(ifB.LSURWM), 64'h0);
        tick();
        chk("to_sc_squash", 64'(ifB.SquashSCW), 64'h1);

        // Timeout disabled vs. 128 and 4 after 1000 cycles
        lr(1'b0, 56'h6000); tick();
        idle(); repeat (1000) tick();
        chk("noto_valid", 64'(rvC), 64'h1);
        chk("to4_expired", 64'(rvB), 64'h0);
        chk("to128_expired", 64'(rvA), 64'h0);
        sc(1'b0, 56'h6000); @(negedge clk);
        chk("noto_sc_rw", 64'(ifC.LSURWM), 64'h1);
        chk("to128_sc_rw", 64'(ifA.LSURWM), 64'h0);
        tick();
        chk("noto_sc_squash", 64'(ifC.SquashSCW), 64'h0);
        chk("noto_sc_valid", 64'(rvC), 64'h0);
        chk("to128_sc_squash", 64'(ifA.SquashSCW), 64'h1);

        // Stalled SC
        lr(1'b0, 56'h7000); tick();
        chk("stall_lr_valid", 64'(rvA), 64'h1);
        sc(1'b1, 56'h7000); tick();
        chk("stall_pre_squash", 64'(ifA.SquashSCW), 64'h1);
        sc(1'b0, 56'h7000); StallW = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_sc_rw", 64'(ifA.LSURWM), 64'h1);
            tick();
            chk("stall_squash_hold", 64'(ifA.SquashSCW), 64'h1);
            chk("stall_valid_hold", 64'(rvA), 64'h1);
        end
        StallW = 1'b0; tick();
        chk("unstall_squash", 64'(ifA.SquashSCW), 64'h0);
        chk("unstall_valid", 64'(rvA), 64'h0);
        idle(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
